bpu_update: RTL and testbench
=============================

BPU_UPDATE -- requirements
Module: bpu_update

Interface
REQ-001 SHALL use one clock and a synchronous active-low reset, both listed first: i_clk input 1 (rising-edge clock); i_rstn input 1 (synchronous active-low reset).
REQ-002 SHALL have prediction-enqueue ports, driven from the PC-generation stage: i_pred_valid in 1; i_pred_pc in MXLEN; i_pred_jump in 1; i_pred_target in MXLEN; o_pred_ready out 1.
REQ-003 SHALL have resolve ports, in program order, driven from the EXU: i_res_valid in 1; i_res_pc in MXLEN; i_res_is_br in 1; i_res_taken in 1; i_res_target in MXLEN.
REQ-004 SHALL have i_flush in 1, an external pipeline flush.
REQ-005 SHALL have redirect outputs: o_exu_pcRedirect_npc out MXLEN; o_exu_pcRedirect_npc_valid out 1.
REQ-006 SHALL have predictor-update outputs: o_pc_jumpsrc out MXLEN; o_pc_jumpdst out MXLEN; o_ubtb_update, o_upht_update, o_ghr_update, o_satCnt_update, o_last_jump out 1 each.
REQ-007 SHALL have status outputs: o_q_empty out 1; o_order_err out 1 (sticky); o_mispred_cnt out 16.

Function
REQ-008 SHALL hold predictions in an in-order queue of PQ_DEPTH=8 entries {pc, jump, target}, using 4-bit read/write pointers with a wrap bit (full = equal index with different wrap bit).
REQ-009 SHALL drive o_pred_ready = !full && state==RUN, combinationally, with no path from the i_res_* inputs.
REQ-010 SHALL enqueue on a clock edge where i_pred_valid && o_pred_ready; an enqueue while not ready SHALL be dropped.
REQ-011 SHALL pop the head entry on a clock edge where i_res_valid && !empty && state==RUN; a resolve while empty SHALL be ignored and SHALL set o_order_err.
REQ-012 SHALL perform an enqueue and a pop in the same cycle when both are legal, leaving occupancy unchanged.
REQ-013 SHALL set o_order_err (sticky until reset) when i_res_pc != head.pc on a pop; the pop SHALL still proceed.
REQ-014 SHALL define mispredict = (i_res_taken != head.jump) || (i_res_taken && i_res_target != head.target); a non-branch (i_res_is_br=0) SHALL be treated as i_res_taken=0.
REQ-015 SHALL define the correct next PC as i_res_taken ? i_res_target : i_res_pc+4, truncated to MXLEN (wrap-around permitted).
REQ-016 SHALL, one cycle after a mispredicting pop, pulse o_exu_pcRedirect_npc_valid=1 for exactly one cycle with o_exu_pcRedirect_npc = the correct next PC; o_exu_pcRedirect_npc SHALL otherwise hold its last value.
REQ-017 SHALL use the state machine RUN/FLUSH: a mispredicting pop moves RUN->FLUSH and clears the queue at that edge; FLUSH->RUN occurs unconditionally after one cycle.
REQ-018 SHALL, while in FLUSH, block enqueue and ignore resolves (wrong-path traffic).
REQ-019 SHALL, one cycle after a popped branch (i_res_is_br=1), pulse o_ghr_update, o_upht_update and o_satCnt_update for one cycle, with o_last_jump=i_res_taken, o_pc_jumpsrc=i_res_pc and o_pc_jumpdst=i_res_target registered alongside.
REQ-020 SHALL pulse o_ubtb_update in the same cycle only when i_res_taken && (!head.jump || i_res_target != head.target).
REQ-021 SHALL generate no update pulses for a non-branch pop; such a pop SHALL still redirect to pc+4 if head.jump=1.
REQ-022 SHALL increment o_mispred_cnt on each mispredicting pop, saturating at 16'hFFFF.
REQ-023 SHALL, on i_flush, empty the queue and set state=RUN at that edge, and suppress all pulses for the following cycle; i_flush SHALL take priority over a simultaneous resolve or enqueue.
REQ-024 SHALL drive o_q_empty directly from the pointers.

Reset
REQ-025 SHALL, on i_rstn=0 at a clock edge: set pointers to 0 (queue empty, o_q_empty=1), state=RUN, all pulse outputs 0, o_exu_pcRedirect_npc/o_pc_jumpsrc/o_pc_jumpdst=0, o_order_err=0, o_mispred_cnt=0.
REQ-026 SHALL let reset override every concurrent event, including reset asserted during FLUSH.
REQ-027 SHALL leave queue entry payload storage unreset.

Structure
REQ-028 SHALL place PQ_DEPTH, the pred-entry struct typedef and the state enum in bpu_pkg; MXLEN SHALL come from the existing `MXLEN macro.
REQ-029 SHALL implement the queue as one sub-module, pred_queue (push/pop/clear/full/empty/head).

Verification
REQ-030 Enqueue {pc=0x100, jump=1, tgt=0x200}; resolve pc=0x100 taken tgt=0x200 -> no redirect; next cycle ghr/upht/satCnt pulse, ubtb=0, last_jump=1.
REQ-031 Enqueue {0x100, jump=0}; resolve taken tgt=0x300 -> next cycle redirect valid with npc=0x300, ubtb_update=1, o_mispred_cnt=1, queue empty, o_pred_ready=0 for one cycle.
REQ-032 Enqueue {0x104, jump=1, tgt=0x400}; resolve not-taken -> redirect npc=0x108; pc=0xFFFFFFFC not-taken mispredict (MXLEN=32) -> npc=0x0.
REQ-033 Fill 8 entries -> o_pred_ready=0; a 9th enqueue is dropped; simultaneous pop+push at 7 entries -> count stays 7.
REQ-034 Resolve with queue empty, or with pc 0x100 vs head 0x104 -> o_order_err=1 and stays 1 until reset.
REQ-035 Assert i_flush together with a mispredicting resolve -> no redirect, queue empty; assert i_rstn=0 during FLUSH -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types for the branch-predictor update block: queue geometry, prediction entry, FSM states.
// Supplies a default MXLEN when the enclosing build has not defined one.
`ifndef MXLEN
`define MXLEN 32
`endif

package bpu_pkg;
  localparam int XLEN     = `MXLEN;
  localparam int PQ_DEPTH = 8;
  localparam int PQ_AW    = $clog2(PQ_DEPTH);
  localparam int PQ_PW    = PQ_AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            jump;
    logic [XLEN-1:0] target;
  } pred_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } bpu_state_e;
endpackage

// File: rtl/pred_queue.sv
// In-order prediction queue: head is visible combinationally, push/pop take effect at the edge.
// Clear overrides push and pop; the caller must not push when full.
module pred_queue
  import bpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_push,
  input  pred_entry_t i_push_dat,
  input  logic        i_pop,
  input  logic        i_clear,
  output logic        o_full,
  output logic        o_empty,
  output pred_entry_t o_head
);
  logic [PQ_PW-1:0] r_wr_ptr;
  logic [PQ_PW-1:0] r_rd_ptr;
  pred_entry_t      r_mem [PQ_DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PQ_AW] != r_rd_ptr[PQ_AW]) &&
                     (r_wr_ptr[PQ_AW-1:0] == r_rd_ptr[PQ_AW-1:0]);
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;
  assign o_head    = r_mem[r_rd_ptr[PQ_AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Payload storage carries no reset; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PQ_AW-1:0]] <= i_push_dat;
  end
endmodule

// File: rtl/bpu_update.sv
// Matches in-order EXU resolves against queued predictions; redirect and predictor-update pulses one cycle after the pop.
// o_pred_ready drops when the queue is full or for the single FLUSH cycle after a mispredict.
module bpu_update
  import bpu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_pred_valid,
  input  logic [XLEN-1:0] i_pred_pc,
  input  logic            i_pred_jump,
  input  logic [XLEN-1:0] i_pred_target,
  output logic            o_pred_ready,
  input  logic            i_res_valid,
  input  logic [XLEN-1:0] i_res_pc,
  input  logic            i_res_is_br,
  input  logic            i_res_taken,
  input  logic [XLEN-1:0] i_res_target,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_exu_pcRedirect_npc,
  output logic            o_exu_pcRedirect_npc_valid,
  output logic [XLEN-1:0] o_pc_jumpsrc,
  output logic [XLEN-1:0] o_pc_jumpdst,
  output logic            o_ubtb_update,
  output logic            o_upht_update,
  output logic            o_ghr_update,
  output logic            o_satCnt_update,
  output logic            o_last_jump,
  output logic            o_q_empty,
  output logic            o_order_err,
  output logic [15:0]     o_mispred_cnt
);
  bpu_state_e      r_state;
  bpu_state_e      w_state_nxt;
  logic            w_full;
  logic            w_empty;
  pred_entry_t     w_head;
  pred_entry_t     w_push_dat;
  logic            w_push;
  logic            w_res_act;
  logic            w_pop;
  logic            w_taken;
  logic            w_mispred;
  logic            w_tgt_diff;
  logic            w_clear;
  logic [XLEN-1:0] w_npc;

  logic            r_redir_vld;
  logic [XLEN-1:0] r_npc;
  logic [XLEN-1:0] r_jumpsrc;
  logic [XLEN-1:0] r_jumpdst;
  logic            r_br_upd;
  logic            r_ubtb_upd;
  logic            r_last_jump;
  logic            r_order_err;
  logic [15:0]     r_mispred_cnt;

  assign o_pred_ready = !w_full && (r_state == ST_RUN);
  assign w_push       = i_pred_valid && o_pred_ready && !i_flush;
  assign w_push_dat   = '{pc: i_pred_pc, jump: i_pred_jump, target: i_pred_target};

  // Resolves arriving during FLUSH belong to the squashed path.
  assign w_res_act  = i_res_valid && (r_state == ST_RUN) && !i_flush;
  assign w_pop      = w_res_act && !w_empty;
  assign w_taken    = i_res_is_br && i_res_taken;
  assign w_tgt_diff = (i_res_target != w_head.target);
  assign w_mispred  = (w_taken != w_head.jump) || (w_taken && w_tgt_diff);
  assign w_npc      = w_taken ? i_res_target : (i_res_pc + XLEN'(4));
  assign w_clear    = i_flush || (w_pop && w_mispred);

  pred_queue u_pred_queue (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_clear    (w_clear),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (w_head)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:   if (w_pop && w_mispred) w_state_nxt = ST_FLUSH;
        ST_FLUSH: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_redir_vld   <= 1'b0;
      r_npc         <= '0;
      r_jumpsrc     <= '0;
      r_jumpdst     <= '0;
      r_br_upd      <= 1'b0;
      r_ubtb_upd    <= 1'b0;
      r_last_jump   <= 1'b0;
      r_order_err   <= 1'b0;
      r_mispred_cnt <= '0;
    end else begin
      r_redir_vld <= w_pop && w_mispred;
      r_br_upd    <= w_pop && i_res_is_br;
      r_ubtb_upd  <= w_pop && w_taken && (!w_head.jump || w_tgt_diff);
      if (w_pop && w_mispred) begin
        r_npc <= w_npc;
        if (r_mispred_cnt != 16'hFFFF) r_mispred_cnt <= r_mispred_cnt + 16'd1;
      end
      if (w_pop && i_res_is_br) begin
        r_last_jump <= i_res_taken;
        r_jumpsrc   <= i_res_pc;
        r_jumpdst   <= i_res_target;
      end
      if (w_res_act && (w_empty || (i_res_pc != w_head.pc))) r_order_err <= 1'b1;
    end
  end

  assign o_exu_pcRedirect_npc       = r_npc;
  assign o_exu_pcRedirect_npc_valid = r_redir_vld;
  assign o_pc_jumpsrc               = r_jumpsrc;
  assign o_pc_jumpdst               = r_jumpdst;
  assign o_ubtb_update              = r_ubtb_upd;
  assign o_upht_update              = r_br_upd;
  assign o_ghr_update               = r_br_upd;
  assign o_satCnt_update            = r_br_upd;
  assign o_last_jump                = r_last_jump;
  assign o_q_empty                  = w_empty;
  assign o_order_err                = r_order_err;
  assign o_mispred_cnt              = r_mispred_cnt;
endmodule

// File: tb/tb_bpu_update.sv
// Bench for bpu_update: directed scenarios plus a long random run against a queue-based reference model.
module tb_bpu_update;
  localparam int XL = `MXLEN;

  logic          i_clk, i_rstn;
  logic          i_pred_valid, i_pred_jump, o_pred_ready;
  logic [XL-1:0] i_pred_pc, i_pred_target;
  logic          i_res_valid, i_res_is_br, i_res_taken, i_flush;
  logic [XL-1:0] i_res_pc, i_res_target;
  logic [XL-1:0] o_exu_pcRedirect_npc, o_pc_jumpsrc, o_pc_jumpdst;
  logic          o_exu_pcRedirect_npc_valid, o_ubtb_update, o_upht_update, o_ghr_update;
  logic          o_satCnt_update, o_last_jump, o_q_empty, o_order_err;
  logic [15:0]   o_mispred_cnt;

  bpu_update dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc), .i_pred_jump(i_pred_jump),
    .i_pred_target(i_pred_target), .o_pred_ready(o_pred_ready),
    .i_res_valid(i_res_valid), .i_res_pc(i_res_pc), .i_res_is_br(i_res_is_br),
    .i_res_taken(i_res_taken), .i_res_target(i_res_target), .i_flush(i_flush),
    .o_exu_pcRedirect_npc(o_exu_pcRedirect_npc), .o_exu_pcRedirect_npc_valid(o_exu_pcRedirect_npc_valid),
    .o_pc_jumpsrc(o_pc_jumpsrc), .o_pc_jumpdst(o_pc_jumpdst), .o_ubtb_update(o_ubtb_update),
    .o_upht_update(o_upht_update), .o_ghr_update(o_ghr_update), .o_satCnt_update(o_satCnt_update),
    .o_last_jump(o_last_jump), .o_q_empty(o_q_empty), .o_order_err(o_order_err),
    .o_mispred_cnt(o_mispred_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a list of outstanding predictions plus the externally visible registers.
  typedef struct { logic [XL-1:0] pc; logic jump; logic [XL-1:0] tgt; } ment_t;
  ment_t         mq[$];
  logic          m_flushing, m_err, m_redir, m_upd, m_ubtb, m_last;
  logic [XL-1:0] m_npc, m_src, m_dst;
  int            m_cnt;

  task automatic mreset();
    mq.delete();
    m_flushing = 0; m_err = 0; m_redir = 0; m_upd = 0; m_ubtb = 0; m_last = 0;
    m_npc = '0; m_src = '0; m_dst = '0; m_cnt = 0;
  endtask

  task automatic mstep();
    ment_t h;
    logic  tk, mis, rdy;
    if (!i_rstn) begin mreset(); return; end
    rdy = (mq.size() < 8) && !m_flushing;
    m_redir = 0; m_upd = 0; m_ubtb = 0; mis = 0;
    if (i_flush) begin mq.delete(); m_flushing = 0; return; end
    if (i_res_valid && !m_flushing) begin
      if (mq.size() == 0) m_err = 1;
      else begin
        h  = mq.pop_front();
        tk = i_res_is_br && i_res_taken;
        if (i_res_pc != h.pc) m_err = 1;
        mis = (tk != h.jump) || (tk && i_res_target != h.tgt);
        if (mis) begin
          m_redir = 1;
          m_npc   = tk ? i_res_target : XL'(i_res_pc + 4);
          if (m_cnt < 65535) m_cnt++;
        end
        if (i_res_is_br) begin
          m_upd = 1; m_last = i_res_taken; m_src = i_res_pc; m_dst = i_res_target;
          m_ubtb = tk && (!h.jump || i_res_target != h.tgt);
        end
      end
    end
    if (mis) begin mq.delete(); m_flushing = 1; end
    else begin
      m_flushing = 0;
      if (i_pred_valid && rdy) mq.push_back('{i_pred_pc, i_pred_jump, i_pred_target});
    end
  endtask

  task automatic set_idle();
    i_pred_valid = 0; i_pred_pc = '0; i_pred_jump = 0; i_pred_target = '0;
    i_res_valid = 0; i_res_pc = '0; i_res_is_br = 0; i_res_taken = 0; i_res_target = '0;
    i_flush = 0;
  endtask

  task automatic set_push(input logic [XL-1:0] pc, input logic j, input logic [XL-1:0] t);
    i_pred_valid = 1; i_pred_pc = pc; i_pred_jump = j; i_pred_target = t;
  endtask

  task automatic set_res(input logic [XL-1:0] pc, input logic br, input logic tk, input logic [XL-1:0] t);
    i_res_valid = 1; i_res_pc = pc; i_res_is_br = br; i_res_taken = tk; i_res_target = t;
  endtask

  task automatic tick();
    mstep();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle(); i_rstn = 0; tick(); tick(); i_rstn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 4;
    if (o_q_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", o_q_empty); end
    if (o_pred_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", o_pred_ready); end
    if ({o_exu_pcRedirect_npc_valid, o_ghr_update, o_ubtb_update, o_order_err, o_last_jump} !== 5'b0)
      begin n_fail++; $display("FAIL reset_flags nonzero"); end
    if (o_exu_pcRedirect_npc !== '0 || o_pc_jumpsrc !== '0 || o_pc_jumpdst !== '0 || o_mispred_cnt !== 16'd0)
      begin n_fail++; $display("FAIL reset_values npc %h src %h dst %h cnt %0d want 0", o_exu_pcRedirect_npc, o_pc_jumpsrc, o_pc_jumpdst, o_mispred_cnt); end
  endtask

  task automatic test_correct_pred();
    set_idle(); set_push(32'h100, 1, 32'h200); tick();
    set_idle(); set_res(32'h100, 1, 1, 32'h200); tick();
    set_idle();
    n_tests += 3;
    if (o_exu_pcRedirect_npc_valid !== 1'b0) begin n_fail++; $display("FAIL correct_no_redirect got 1 want 0"); end
    if ({o_ghr_update, o_upht_update, o_satCnt_update, o_ubtb_update, o_last_jump} !== 5'b11101)
      begin n_fail++; $display("FAIL correct_pulses got %b want 11101", {o_ghr_update, o_upht_update, o_satCnt_update, o_ubtb_update, o_last_jump}); end
    if (o_pc_jumpsrc !== 32'h100 || o_pc_jumpdst !== 32'h200 || o_q_empty !== 1'b1)
      begin n_fail++; $display("FAIL correct_regs src %h dst %h empty %b want 100 200 1", o_pc_jumpsrc, o_pc_jumpdst, o_q_empty); end
    tick();
    n_tests++;
    if (o_ghr_update !== 1'b0) begin n_fail++; $display("FAIL correct_pulse_width ghr got 1 want 0"); end
  endtask

  task automatic test_mispredict();
    set_idle(); set_push(32'h100, 0, 32'h0); tick();
    set_idle(); set_res(32'h100, 1, 1, 32'h300); tick();
    set_idle();
    n_tests += 4;
    if (o_exu_pcRedirect_npc_valid !== 1'b1 || o_exu_pcRedirect_npc !== 32'h300)
      begin n_fail++; $display("FAIL mispred_redirect vld %b npc %h want 1 300", o_exu_pcRedirect_npc_valid, o_exu_pcRedirect_npc); end
    if (o_ubtb_update !== 1'b1) begin n_fail++; $display("FAIL mispred_ubtb got 0 want 1"); end
    if (o_mispred_cnt !== 16'd1 || o_q_empty !== 1'b1)
      begin n_fail++; $display("FAIL mispred_cnt_empty cnt %0d empty %b want 1 1", o_mispred_cnt, o_q_empty); end
    if (o_pred_ready !== 1'b0) begin n_fail++; $display("FAIL mispred_ready_flush got 1 want 0"); end
    tick();
    n_tests++;
    if (o_pred_ready !== 1'b1 || o_exu_pcRedirect_npc_valid !== 1'b0 || o_exu_pcRedirect_npc !== 32'h300)
      begin n_fail++; $display("FAIL mispred_after ready %b vld %b npc %h want 1 0 300", o_pred_ready, o_exu_pcRedirect_npc_valid, o_exu_pcRedirect_npc); end
  endtask

  task automatic test_redirect_pc4();
    set_idle(); set_push(32'h104, 1, 32'h400); tick();
    set_idle(); set_res(32'h104, 1, 0, 32'h0); tick();
    set_idle();
    n_tests++;
    if (o_exu_pcRedirect_npc_valid !== 1'b1 || o_exu_pcRedirect_npc !== 32'h108)
      begin n_fail++; $display("FAIL pc4_redirect vld %b npc %h want 1 108", o_exu_pcRedirect_npc_valid, o_exu_pcRedirect_npc); end
    tick();
    set_push(32'hFFFF_FFFC, 1, 32'h10); tick();
    set_idle(); set_res(32'hFFFF_FFFC, 1, 0, 32'h0); tick();
    set_idle();
    n_tests++;
    if (o_exu_pcRedirect_npc_valid !== 1'b1 || o_exu_pcRedirect_npc !== 32'h0 || o_mispred_cnt !== 16'd3)
      begin n_fail++; $display("FAIL pc4_wrap vld %b npc %h cnt %0d want 1 0 3", o_exu_pcRedirect_npc_valid, o_exu_pcRedirect_npc, o_mispred_cnt); end
    tick();
  endtask

  task automatic test_full();
    logic [XL-1:0] exp_pc[8];
    for (int i = 0; i < 8; i++) begin set_idle(); set_push(XL'(32'h1000 + 4 * i), 0, '0); tick(); end
    n_tests++;
    if (o_pred_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got 1 want 0"); end
    set_idle(); set_push(32'h2000, 0, '0); tick();
    set_idle(); set_res(32'h1000, 0, 0, '0); tick();
    n_tests++;
    if (o_pred_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop ready got 0 want 1"); end
    set_idle(); set_res(32'h1004, 0, 0, '0); set_push(32'h3000, 0, '0); tick();
    set_idle(); set_push(32'h3004, 0, '0); tick();
    set_idle();
    n_tests++;
    if (o_pred_ready !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_count ready got 1 want 0 (7+1 entries)"); end
    for (int i = 0; i < 6; i++) exp_pc[i] = XL'(32'h1008 + 4 * i);
    exp_pc[6] = 32'h3000; exp_pc[7] = 32'h3004;
    for (int i = 0; i < 8; i++) begin set_idle(); set_res(exp_pc[i], 0, 0, '0); tick(); end
    set_idle();
    n_tests++;
    if (o_q_empty !== 1'b1 || o_order_err !== 1'b0 || o_exu_pcRedirect_npc_valid !== 1'b0)
      begin n_fail++; $display("FAIL full_drain empty %b err %b vld %b want 1 0 0", o_q_empty, o_order_err, o_exu_pcRedirect_npc_valid); end
  endtask

  task automatic test_order_err();
    set_idle(); set_res(32'h100, 1, 0, '0); tick();
    set_idle();
    n_tests++;
    if (o_order_err !== 1'b1) begin n_fail++; $display("FAIL order_empty got 0 want 1"); end
    do_reset();
    set_push(32'h104, 0, '0); tick();
    set_idle(); set_res(32'h100, 0, 0, '0); tick();
    set_idle(); tick(); tick();
    n_tests++;
    if (o_order_err !== 1'b1 || o_q_empty !== 1'b1)
      begin n_fail++; $display("FAIL order_pc_mismatch err %b empty %b want 1 1", o_order_err, o_q_empty); end
    do_reset();
    n_tests++;
    if (o_order_err !== 1'b0) begin n_fail++; $display("FAIL order_cleared_by_reset got 1 want 0"); end
  endtask

  task automatic test_flush_reset();
    set_idle(); set_push(32'h100, 0, '0); tick();
    set_idle(); set_res(32'h100, 1, 1, 32'h300); i_flush = 1; tick();
    set_idle();
    n_tests++;
    if (o_exu_pcRedirect_npc_valid !== 1'b0 || o_ghr_update !== 1'b0 || o_q_empty !== 1'b1 || o_pred_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_priority vld %b ghr %b empty %b ready %b want 0 0 1 1", o_exu_pcRedirect_npc_valid, o_ghr_update, o_q_empty, o_pred_ready); end
    set_push(32'h100, 0, '0); tick();
    set_idle(); set_res(32'h100, 1, 1, 32'h300); tick();
    set_idle(); i_rstn = 0; tick(); i_rstn = 1;
    n_tests++;
    if ({o_exu_pcRedirect_npc_valid, o_ghr_update, o_ubtb_update, o_last_jump, o_order_err} !== 5'b0 ||
        o_exu_pcRedirect_npc !== '0 || o_pc_jumpsrc !== '0 || o_pc_jumpdst !== '0 || o_mispred_cnt !== 16'd0 ||
        o_q_empty !== 1'b1 || o_pred_ready !== 1'b1)
      begin n_fail++; $display("FAIL reset_in_flush npc %h src %h cnt %0d empty %b ready %b want 0 0 0 1 1", o_exu_pcRedirect_npc, o_pc_jumpsrc, o_mispred_cnt, o_q_empty, o_pred_ready); end
  endtask

  task automatic test_random();
    logic exp_rdy;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      set_idle();
      i_rstn        = ($urandom_range(0, 299) != 0);
      i_flush       = ($urandom_range(0, 39) == 0);
      i_pred_valid  = ($urandom_range(0, 9) < 6);
      i_pred_pc     = XL'($urandom_range(0, 255)) << 2;
      i_pred_jump   = $urandom_range(0, 1) == 1;
      i_pred_target = XL'($urandom_range(0, 255)) << 2;
      i_res_valid   = ($urandom_range(0, 9) < 4);
      i_res_is_br   = ($urandom_range(0, 9) < 8);
      i_res_taken   = $urandom_range(0, 1) == 1;
      i_res_pc      = (mq.size() > 0 && $urandom_range(0, 19) != 0) ? mq[0].pc : XL'($urandom_range(0, 255)) << 2;
      i_res_target  = (mq.size() > 0 && $urandom_range(0, 2) != 0) ? mq[0].tgt : XL'($urandom_range(0, 255)) << 2;
      exp_rdy = (mq.size() < 8) && !m_flushing;
      n_tests++;
      if (o_pred_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", c, o_pred_ready, exp_rdy); end
      tick();
      n_tests += 3;
      if ({o_exu_pcRedirect_npc_valid, o_ghr_update, o_upht_update, o_satCnt_update, o_ubtb_update} !== {m_redir, m_upd, m_upd, m_upd, m_ubtb})
        begin n_fail++; $display("FAIL rand_pulses cyc %0d got %b want %b", c, {o_exu_pcRedirect_npc_valid, o_ghr_update, o_upht_update, o_satCnt_update, o_ubtb_update}, {m_redir, m_upd, m_upd, m_upd, m_ubtb}); end
      if (o_exu_pcRedirect_npc !== m_npc || o_pc_jumpsrc !== m_src || o_pc_jumpdst !== m_dst || o_last_jump !== m_last)
        begin n_fail++; $display("FAIL rand_regs cyc %0d npc %h/%h src %h/%h dst %h/%h lj %b/%b", c, o_exu_pcRedirect_npc, m_npc, o_pc_jumpsrc, m_src, o_pc_jumpdst, m_dst, o_last_jump, m_last); end
      if (o_q_empty !== (mq.size() == 0) || o_order_err !== m_err || o_mispred_cnt !== 16'(m_cnt))
        begin n_fail++; $display("FAIL rand_status cyc %0d empty %b err %b/%b cnt %0d/%0d qsize %0d", c, o_q_empty, o_order_err, m_err, o_mispred_cnt, m_cnt, mq.size()); end
    end
    i_rstn = 1;
  endtask

  initial begin
    mreset();
    set_idle();
    i_rstn = 0;
    test_reset();
    test_correct_pred();
    test_mispredict();
    test_redirect_pc4();
    test_full();
    test_order_err();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
